// File: rtl/rst_seq_sys.sv
// rst_seq_sys: sequences debug, peripheral and core reset releases from one raw system reset;
// software requests re-sequence peripheral and core only, leaving the debug domain up.
module rst_seq_sys #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CORE_DELAY  = 4
) (
    input  logic clk_sys,
    input  logic rst_sys_n,
    input  logic sw_rst_req_i,
    output logic rst_dbg_n_o,
    output logic rst_periph_n_o,
    output logic rst_core_n_o,
    output logic rst_done_o,
    output logic rst_cause_o
);
    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_HOLD  = 3'd1;
    localparam logic [2:0] S_DELAY = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_SWRST = 3'd4;
    localparam logic [15:0] HOLD_LD = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] SW_LD   = 16'(HOLD_CYCLES > 1 ? HOLD_CYCLES - 2 : 0);
    localparam logic [15:0] CORE_LD = 16'(CORE_DELAY > 0 ? CORE_DELAY - 1 : 0);

    logic [SYNC_STAGES-1:0] sync;
    logic [2:0]             state;
    logic [15:0]            cnt;
    logic                   sw_hit;
    logic                   rel_p;

    assign rst_dbg_n_o = sync[SYNC_STAGES-1];
    assign sw_hit = sw_rst_req_i && (state == S_HOLD || state == S_DELAY || state == S_RUN);
    // SWRST skips HOLD entirely when a single hold cycle is already spent in SWRST itself
    assign rel_p = !sw_rst_req_i &&
                   ((state == S_HOLD && cnt == '0) || (state == S_SWRST && HOLD_CYCLES == 1));

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            sync           <= '0;
            state          <= S_RESET;
            cnt            <= '0;
            rst_periph_n_o <= 1'b0;
            rst_core_n_o   <= 1'b0;
            rst_done_o     <= 1'b0;
            rst_cause_o    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
            if (sw_hit) begin
                state          <= S_SWRST;
                rst_periph_n_o <= 1'b0;
                rst_core_n_o   <= 1'b0;
                rst_done_o     <= 1'b0;
                rst_cause_o    <= 1'b1;
            end else if (rel_p) begin
                rst_periph_n_o <= 1'b1;
                if (CORE_DELAY == 0) begin
                    rst_core_n_o <= 1'b1;
                    rst_done_o   <= 1'b1;
                    state        <= S_RUN;
                end else begin
                    cnt   <= CORE_LD;
                    state <= S_DELAY;
                end
            end else if (state == S_RESET) begin
                // look one stage early so HOLD starts on the edge the debug reset releases
                if (sync[SYNC_STAGES-2]) begin
                    state <= S_HOLD;
                    cnt   <= HOLD_LD;
                end
            end else if (state == S_HOLD || state == S_DELAY) begin
                if (cnt != '0) begin
                    cnt <= cnt - 16'd1;
                end else begin
                    rst_core_n_o <= 1'b1;
                    rst_done_o   <= 1'b1;
                    state        <= S_RUN;
                end
            end else if (state == S_SWRST) begin
                if (!sw_rst_req_i) begin
                    cnt   <= SW_LD;
                    state <= S_HOLD;
                end
            end else if (state != S_RUN) begin
                state <= S_RESET;
            end
        end
    end
endmodule

// File: tb/tb_rst_seq_sys.sv
// tb_rst_seq_sys: scoreboard bench; an edge-count model predicts every output transition of a
// default instance and a SYNC_STAGES=3/HOLD_CYCLES=1/CORE_DELAY=0 instance under random requests.
module tb_rst_seq_sys;
    typedef struct {
        int         ed;
        logic [4:0] vec;
    } ev_t;

    logic       clk_sys   = 1'b0;
    logic       rst_sys_n = 1'b1;
    logic       sw        = 1'b0;
    logic [4:0] o0, o1;
    ev_t        q[2][$];
    int         ps[2] = '{2, 3};
    int         ph[2] = '{16, 1};
    int         pd[2] = '{4, 0};
    int         k[2]  = '{-1, -1};
    logic [4:0] pexp[2] = '{5'd0, 5'd0};
    logic [4:0] lastd[2] = '{5'd0, 5'd0};
    int         n = 0;
    int         checks = 0;
    int         passes = 0;
    int         mb;
    logic       mc;
    logic [4:0] mex;
    logic [4:0] d;
    ev_t        ev;

    always #5 clk_sys = ~clk_sys;

    rst_seq_sys #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .CORE_DELAY(4)) u0 (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .sw_rst_req_i(sw),
        .rst_dbg_n_o(o0[4]), .rst_periph_n_o(o0[3]), .rst_core_n_o(o0[2]),
        .rst_done_o(o0[1]), .rst_cause_o(o0[0])
    );

    rst_seq_sys #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .CORE_DELAY(0)) u1 (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .sw_rst_req_i(sw),
        .rst_dbg_n_o(o1[4]), .rst_periph_n_o(o1[3]), .rst_core_n_o(o1[2]),
        .rst_done_o(o1[1]), .rst_cause_o(o1[0])
    );

    function automatic void chk(input string nm, input int i, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s inst%0d at edge %0d: got %0d, expected %0d", nm, i, n, got, exp);
    endfunction

    task automatic tick(input int c);
        repeat (c) @(negedge clk_sys);
    endtask

    // reference model: outputs follow from the edge count and the last accepted request edge
    initial forever begin
        @(posedge clk_sys or negedge rst_sys_n);
        if (!rst_sys_n) begin
            n = 0;
            k = '{-1, -1};
        end else begin
            n++;
            for (int i = 0; i < 2; i++) if (sw && n > ps[i]) k[i] = n;
        end
        for (int i = 0; i < 2; i++) begin
            mb  = (k[i] < 0) ? ps[i] : k[i];
            mc  = (n >= mb + ph[i] + pd[i]);
            mex = {n >= ps[i], n >= mb + ph[i], mc, mc, k[i] >= 0};
            if (mex != pexp[i]) begin
                q[i].push_back('{ed: n, vec: mex});
                pexp[i] = mex;
            end
        end
    end

    // monitor: every output change (or overdue expected change) consumes one scoreboard entry
    initial forever begin
        @(negedge clk_sys);
        for (int i = 0; i < 2; i++) begin
            d = (i == 0) ? o0 : o1;
            chk("order", i, {29'd0, d[4] >= d[3], d[3] >= d[2], d[1] == d[2]}, 7);
            if (d != lastd[i] || (q[i].size() > 0 && q[i][0].ed <= n)) begin
                if (q[i].size() == 0) begin
                    chk("spurious_toggle", i, 32'(d), 32'(lastd[i]));
                end else begin
                    ev = q[i].pop_front();
                    chk("event_edge", i, n, ev.ed);
                    chk("event_value", i, 32'(d), 32'(ev.vec));
                end
                lastd[i] = d;
            end
        end
    end

    initial begin
        #1 rst_sys_n = 1'b0;
        #1;
        chk("reset_state", 0, 32'(o0), 0);
        chk("reset_state", 1, 32'(o1), 0);
        tick(2);
        rst_sys_n = 1'b1;
        tick(30);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        tick(30);
        sw = 1'b1;
        tick(10);
        sw = 1'b0;
        tick(18);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        tick(30);
        repeat (8) begin
            tick($urandom_range(0, 25));
            sw = 1'b1;
            tick($urandom_range(1, 4));
            sw = 1'b0;
        end
        tick(30);
        rst_sys_n = 1'b0;
        tick(2);
        rst_sys_n = 1'b1;
        tick(8);
        @(posedge clk_sys);
        #2 rst_sys_n = 1'b0;
        #1;
        chk("async_assert", 0, 32'(o0), 0);
        chk("async_assert", 1, 32'(o1), 0);
        tick(2);
        rst_sys_n = 1'b1;
        tick(30);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        tick(30);
        chk("drain", 0, q[0].size(), 0);
        chk("drain", 1, q[1].size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/rst_seq_sys.md
# rst_seq_sys

Reset sequencer on the consuming side of the system clock generator. It takes the raw `clk_sys` and the unsynchronised `rst_sys_n` (external reset combined with PLL lock) and produces three glitch-free reset domains:
- a debug domain, released first;
- a peripheral domain, released after a programmable hold;
- a core domain, released last.

Debug-initiated resets re-sequence peripheral and core only, so the debug module and ILA stay connected.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: reset-deassertion synchroniser depth; legal 2..4.
- `HOLD_CYCLES`, default 16: cycles between debug release and peripheral release; legal 1..65535.
- `CORE_DELAY`, default 4: cycles between peripheral release and core release; legal 0..255.

Ports:
- `clk_sys`, input, 1: system clock, single clock domain.
- `rst_sys_n`, input, 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised internally.
- `sw_rst_req_i`, input, 1: software/debug reset request (ndmreset). Synchronous to `clk_sys`, level-sensitive, not re-synchronised.
- `rst_dbg_n_o`, output, 1: debug-domain reset, active-low.
- `rst_periph_n_o`, output, 1: peripheral-domain reset, active-low.
- `rst_core_n_o`, output, 1: core-domain reset, active-low.
- `rst_done_o`, output, 1: high while all domains are released.
- `rst_cause_o`, output, 1: 0 means the last reset was power-on/external; 1 means it was a software request.

## Operation
- All outputs come straight from flops with no combinational logic after the flops. They assert asynchronously when `rst_sys_n` goes low.
- Reset values:
  - `rst_dbg_n_o`, `rst_periph_n_o`, `rst_core_n_o`, `rst_done_o` = 0.
  - `rst_cause_o` = 0.
  - Synchroniser chain all 0.
  - FSM in `RESET`.
  - Counter = 0.
- Synchroniser: a `SYNC_STAGES`-deep chain shifts in 1 each edge while `rst_sys_n` is high. The chain output drives `rst_dbg_n_o` directly. `sw_rst_req_i` never affects it.
- FSM states and transitions:
  - `RESET`: waits for the chain output to be 1. On that edge go to `HOLD` and load the counter with `HOLD_CYCLES-1`.
  - `HOLD`: decrements the counter. At 0, set `rst_periph_n_o` to 1, load the counter with `CORE_DELAY-1`, and go to `DELAY`. If `CORE_DELAY`=0, go directly to `RUN` and release core in the same edge.
  - `DELAY`: decrements the counter. At 0, set `rst_core_n_o` and `rst_done_o` to 1 and go to `RUN`.
  - `RUN`: steady state. `sw_rst_req_i` sampled high goes to `SWRST`, clears `rst_periph_n_o`, `rst_core_n_o` and `rst_done_o`, and sets `rst_cause_o`.
  - `SWRST`: stays while `sw_rst_req_i` is high. The first edge where it is sampled low loads the counter with `HOLD_CYCLES-2` and goes to `HOLD`. If `HOLD_CYCLES`=1, go straight to the peripheral release.
- `sw_rst_req_i` high in `HOLD` or `DELAY`: go to `SWRST`, re-assert `rst_periph_n_o` (it may already be 0) and set `rst_cause_o`. The sequence restarts from scratch.
- `sw_rst_req_i` in `RESET`: ignored.
- `rst_cause_o` is cleared only by `rst_sys_n`.
- `rst_sys_n` asserted mid-sequence, from any state: all outputs go to their reset values immediately. Full power-on sequencing follows on deassertion.
- Counter is 16 bits, counts down, and never wraps. Load values are computed at elaboration.

## Timing
- Edge numbering: edge 1 is the first rising `clk_sys` edge with `rst_sys_n` high, after recovery has been met.
- Power-on release sequence:
  - `rst_dbg_n_o` rises after edge `SYNC_STAGES`.
  - `rst_periph_n_o` rises after edge `SYNC_STAGES+HOLD_CYCLES`.
  - `rst_core_n_o` and `rst_done_o` rise after edge `SYNC_STAGES+HOLD_CYCLES+CORE_DELAY`.
  - With defaults this is edges 2, 18 and 22.
- Software reset: let k be the last edge at which `sw_rst_req_i` is sampled high.
  - Peripheral and core outputs fall after the first such sample edge, giving 1-cycle assertion latency.
  - `rst_periph_n_o` rises after edge `k+HOLD_CYCLES`.
  - Core rises after edge `k+HOLD_CYCLES+CORE_DELAY`.
- Minimum peripheral and core assertion width is `HOLD_CYCLES` (respectively `HOLD_CYCLES+CORE_DELAY`) cycles.
- Release order is always dbg ≤ periph ≤ core.
- `rst_done_o` always equals `rst_core_n_o`.

## Test plan
- Power-on with defaults: deassert `rst_sys_n`, then count edges. Expect dbg rises after edge 2, periph after edge 18, core and done after edge 22, and cause = 0.
- Pulse `sw_rst_req_i` high for 1 cycle at edge k in `RUN`. Expect:
  - periph, core and done are 0 after edge k;
  - periph = 1 after edge k+16;
  - core = 1 after edge k+20;
  - dbg stays 1 throughout;
  - cause = 1.
- Hold `sw_rst_req_i` high for 10 cycles, then re-pulse it during `DELAY` (periph already 1). Expect periph to re-assert 1 edge after the re-pulse, with release timed from the last high sample.
- Assert `rst_sys_n` low asynchronously mid-`HOLD`, between clock edges. Expect all outputs 0 with no clock edge, and a full 2/18/22 sequence after release.
- Parameter sweeps:
  - `SYNC_STAGES`=3, `HOLD_CYCLES`=1, `CORE_DELAY`=0: expect dbg after edge 3, and periph and core together after edge 4.
  - `HOLD_CYCLES`=1 software reset: expect periph and core both rise after edge k+1.
- Glitch check across all runs: each reset output toggles at most once per sequence, and the order assertion dbg ≥ periph ≥ core (as released-levels) holds every cycle.
